bus_arbiter: RTL and testbench

- Two-master arbiter that shares the single QSPI SRAM byte bus (BUS_*) between the instruction/data CACHE (master 0) and a second requester (master 1), e.g. a UART program loader or DMA.
- Sits between CACHE/loader and QSPI_SRAM.
- Registers each granted command, holds it stable to the SRAM controller until BUS_RDY, then returns RDY/RDATA to the owner.
- Round-robin arbitration, with a bounded lock that lets master 1 run multi-byte sequences back to back.

---
 rtl/bus_arb_pkg.sv | 20 ++
 rtl/bus_arbiter_if.sv | 21 ++
 rtl/bus_arb_rr.sv | 34 +++
 rtl/bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types for the two-master QSPI SRAM bus arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   owner_t     : one-hot bus owner, bit 0 = master 0 (cache), bit 1 = master 1
//   LOCK_CNT_W  : width of the master 1 lock counter (MAX_LOCK is 1..255)
package bus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_NONE = 2'b00;
    localparam owner_t OWNER_M0   = 2'b01;
    localparam owner_t OWNER_M1   = 2'b10;

    localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: one byte-bus command/response channel.
//   req/write/addr/wdata : command, driven by the requesting side
//   rdata/rdy            : completion, driven by the serving side
// Modports:
//   master : the side that issues commands (an arbiter client, or the
//            arbiter towards the SRAM controller)
//   slave  : the side that serves commands
interface bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rdy;

    modport master (output req, write, addr, wdata, input rdata, rdy);
    modport slave  (input req, write, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/bus_arb_rr.sv
// bus_arb_rr: pure arbitration decision, no state.
//   req        : {master 1, master 0} request lines
//   last_owner : owner of the most recently completed transfer
//   lock       : master 1 completed its last transfer with LOCK held
//   lock_cnt   : locked grants master 1 has taken since master 0 was served
//   winner     : one-hot master to grant (OWNER_NONE when nobody requests)
// A contested cycle goes to master 1 while its lock is still within budget,
// otherwise to whichever master did not own the bus last.
module bus_arb_rr
    import bus_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic [1:0]            req,
    input  owner_t                last_owner,
    input  logic                  lock,
    input  logic [LOCK_CNT_W-1:0] lock_cnt,
    output owner_t                winner
);

    logic lock_active;
    assign lock_active = lock && (lock_cnt < LOCK_CNT_W'(MAX_LOCK));

    always_comb begin
        winner = OWNER_NONE;
        case (req)
            2'b01:   winner = OWNER_M0;
            2'b10:   winner = OWNER_M1;
            2'b11:   winner = (lock_active || last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
            default: winner = OWNER_NONE;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the QSPI SRAM byte bus between the cache (master 0)
// and a loader/DMA (master 1). A granted command is registered onto the bus
// and held until the SRAM controller pulses rdy; the completion and read
// data are then routed combinationally to the owner only.
// Ports:
//   CLK, RES : clock, synchronous active-high reset
//   m0, m1   : client channels (slave side of bus_arbiter_if)
//   M1_LOCK  : master 1 keeps ownership across back-to-back transfers
//   bus      : channel to the SRAM controller (master side)
//   GNT      : one-hot current owner, 00 when the bus is free
//   WDOG_ERR : sticky stall flag
// Optional feature: define BUS_ARB_WDOG_EN to build the BUSY watchdog that
// raises WDOG_ERR after WDOG_CYCLES cycles without rdy; otherwise WDOG_ERR
// is tied low.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int MAX_LOCK    = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic          CLK,
    input  logic          RES,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    input  logic          M1_LOCK,
    bus_arbiter_if.master bus,
    output owner_t        GNT,
    output logic          WDOG_ERR
);

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_q, last_d;
    logic                  lock_q, lock_d;
    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  write_q, write_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;

    owner_t winner;
    logic   lock_active;
    logic   done;
    logic   m0_done, m1_done;

    bus_arb_rr #(.MAX_LOCK(MAX_LOCK)) u_rr (
        .req        ({m1.req, m0.req}),
        .last_owner (last_q),
        .lock       (lock_q),
        .lock_cnt   (cnt_q),
        .winner     (winner)
    );

    assign lock_active = lock_q && (cnt_q < LOCK_CNT_W'(MAX_LOCK));

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
            owner_q <= OWNER_NONE;
            last_q  <= OWNER_M1;   // master 0 wins the first contested cycle
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                // The lock only carries into the first IDLE cycle after the
                // locked transfer; this arbitration consumes it.
                lock_d = 1'b0;
                if (winner != OWNER_NONE) begin
                    state_d = BUSY;
                    owner_d = winner;
                    req_d   = 1'b1;
                    if (winner == OWNER_M0) begin
                        write_d = m0.write;
                        addr_d  = m0.addr;
                        wdata_d = m0.wdata;
                        cnt_d   = '0;
                    end else begin
                        write_d = m1.write;
                        addr_d  = m1.addr;
                        wdata_d = m1.wdata;
                        if (lock_active)
                            cnt_d = cnt_q + LOCK_CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (bus.rdy) begin
                    state_d = IDLE;
                    owner_d = OWNER_NONE;
                    req_d   = 1'b0;
                    last_d  = owner_q;
                    lock_d  = (owner_q == OWNER_M1) && M1_LOCK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion is suppressed in a reset cycle so an abandoned transfer
    // never reaches its owner.
    assign done    = (state_q == BUSY) && bus.rdy && !RES;
    assign m0_done = done && (owner_q == OWNER_M0);
    assign m1_done = done && (owner_q == OWNER_M1);

    assign m0.rdy   = m0_done;
    assign m1.rdy   = m1_done;
    assign m0.rdata = (m0_done && !write_q) ? bus.rdata : '0;
    assign m1.rdata = (m1_done && !write_q) ? bus.rdata : '0;

    assign bus.req   = req_q;
    assign bus.write = write_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign GNT       = owner_q;

`ifdef BUS_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_err_q;

    // Counts BUSY cycles without rdy; held at zero while IDLE so every
    // transfer starts fresh. The flag is only observed, never aborts.
    always_ff @(posedge CLK) begin
        if (RES) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else if (state_q == IDLE) begin
            wd_cnt_q <= '0;
        end else if (!bus.rdy) begin
            if (wd_cnt_q != WD_W'(WDOG_CYCLES))
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            if (wd_cnt_q == WD_W'(WDOG_CYCLES - 1))
                wd_err_q <= 1'b1;
        end
    end

    assign WDOG_ERR = wd_err_q;
`else
    assign WDOG_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int MAX_LOCK = 4;
    localparam int WDOG     = 8;
`ifdef BUS_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   res;
    logic   m1_lock;
    owner_t gnt;
    logic   wdog_err;

    bus_arbiter_if #(.AW(16), .DW(8)) m0_if ();
    bus_arbiter_if #(.AW(16), .DW(8)) m1_if ();
    bus_arbiter_if #(.AW(16), .DW(8)) bus_if ();

    bus_arbiter #(.AW(16), .DW(8), .MAX_LOCK(MAX_LOCK), .WDOG_CYCLES(WDOG)) dut (
        .CLK      (clk),
        .RES      (res),
        .m0       (m0_if),
        .m1       (m1_if),
        .M1_LOCK  (m1_lock),
        .bus      (bus_if),
        .GNT      (gnt),
        .WDOG_ERR (wdog_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // transaction-level model
    bit        mb_busy;
    int        mb_owner;
    int        mb_last;
    bit        mb_lock;
    int        mb_cnt;
    bit        c_write;
    logic [15:0] c_addr;
    logic [7:0]  c_wdata;
    int        wd_n;
    bit        wd_err;
    bit        last_rdy0, last_rdy1;
    int        sram_wait;

    logic [1:0] seq2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] seq3 [8] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mb_busy = 0; mb_owner = 0; mb_last = 1; mb_lock = 0; mb_cnt = 0;
        c_write = 0; c_addr = '0; c_wdata = '0; wd_n = 0; wd_err = 0;
    endtask

    task automatic check_all();
        bit e0, e1;
        e0 = mb_busy && mb_owner == 0 && bus_if.rdy && !res;
        e1 = mb_busy && mb_owner == 1 && bus_if.rdy && !res;
        chk("bus_req", 32'(bus_if.req), 32'(mb_busy));
        chk("gnt", 32'(gnt), mb_busy ? (mb_owner == 1 ? 32'd2 : 32'd1) : 32'd0);
        chk("bus_write", 32'(bus_if.write), 32'(c_write));
        chk("bus_addr", 32'(bus_if.addr), 32'(c_addr));
        chk("bus_wdata", 32'(bus_if.wdata), 32'(c_wdata));
        chk("m0_rdy", 32'(m0_if.rdy), 32'(e0));
        chk("m1_rdy", 32'(m1_if.rdy), 32'(e1));
        chk("m0_rdata", 32'(m0_if.rdata), (e0 && !c_write) ? 32'(bus_if.rdata) : 32'd0);
        chk("m1_rdata", 32'(m1_if.rdata), (e1 && !c_write) ? 32'(bus_if.rdata) : 32'd0);
        chk("wdog_err", 32'(wdog_err), 32'(wd_err));
        last_rdy0 = e0;
        last_rdy1 = e1;
    endtask

    // Applies the arbitration rules to the inputs present at the clock edge.
    task automatic model_step();
        bit r0, r1, entitled;
        int w;
        r0 = m0_if.req;
        r1 = m1_if.req;
        entitled = mb_lock && (mb_cnt < MAX_LOCK);
        w = -1;
        if (res) begin
            model_reset();
        end else if (mb_busy) begin
            if (bus_if.rdy) begin
                mb_busy = 0;
                mb_last = mb_owner;
                mb_lock = (mb_owner == 1) && m1_lock;
            end else begin
                wd_n++;
                if (wd_n >= WDOG && WDOG_ON) wd_err = 1;
            end
        end else begin
            if (r0 && r1)  w = (entitled || mb_last == 0) ? 1 : 0;
            else if (r0)   w = 0;
            else if (r1)   w = 1;
            mb_lock = 0;
            if (w >= 0) begin
                mb_busy = 1; mb_owner = w; wd_n = 0;
                if (w == 0) begin
                    c_write = m0_if.write; c_addr = m0_if.addr; c_wdata = m0_if.wdata;
                    mb_cnt = 0;
                end else begin
                    c_write = m1_if.write; c_addr = m1_if.addr; c_wdata = m1_if.wdata;
                    if (entitled) mb_cnt++;
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        res = 1'b0;
    endtask

    // one arbitration cycle followed by an immediate SRAM completion
    task automatic grant_and_ack(input string tag, input logic [1:0] exp);
        chk("idle_gap", 32'(gnt), 32'd0);
        tick();
        chk(tag, 32'(gnt), 32'(exp));
        bus_if.rdy = 1'b1;
        tick();
        bus_if.rdy = 1'b0;
    endtask

    initial begin
        res = 1'b1; m1_lock = 1'b0;
        m0_if.req = 0; m0_if.write = 0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 0; m1_if.write = 0; m1_if.addr = '0; m1_if.wdata = '0;
        bus_if.rdy = 0; bus_if.rdata = '0;
        last_rdy0 = 0; last_rdy1 = 0; sram_wait = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        do_reset();

        // single master 0 read
        m0_if.req = 1; m0_if.write = 0; m0_if.addr = 16'h1234;
        tick();
        chk("t1_bus_req", 32'(bus_if.req), 32'd1);
        chk("t1_addr", 32'(bus_if.addr), 32'h1234);
        chk("t1_write", 32'(bus_if.write), 32'd0);
        tick();
        bus_if.rdy = 1; bus_if.rdata = 8'h5A;
        #1;
        chk("t1_m0_rdy", 32'(m0_if.rdy), 32'd1);
        chk("t1_m0_rdata", 32'(m0_if.rdata), 32'h5A);
        tick();
        bus_if.rdy = 0; m0_if.req = 0;
        chk("t1_bus_req_drop", 32'(bus_if.req), 32'd0);
        tick();

        // contested requests alternate
        do_reset();
        m0_if.req = 1; m0_if.addr = 16'h1000;
        m1_if.req = 1; m1_if.addr = 16'h2000;
        for (int k = 0; k < 4; k++) grant_and_ack("t2_alt_gnt", seq2[k]);

        // lock: 1 round-robin + MAX_LOCK locked grants, then master 0
        do_reset();
        m1_lock = 1;
        for (int k = 0; k < 8; k++) grant_and_ack("t3_lock_gnt", seq3[k]);
        m1_lock = 0; m0_if.req = 0; m1_if.req = 0;
        tick();

        // master 1 write, early deasserts on both masters
        do_reset();
        m1_if.req = 1; m1_if.write = 1; m1_if.addr = 16'h0100; m1_if.wdata = 8'hA5;
        tick();
        chk("t4_gnt", 32'(gnt), 32'd2);
        m1_if.req = 0;
        m0_if.req = 1; m0_if.write = 0; m0_if.addr = 16'h0777;
        tick();
        m0_if.req = 0;
        tick();
        bus_if.rdy = 1; bus_if.rdata = 8'hFF;
        #1;
        chk("t4_m1_rdy", 32'(m1_if.rdy), 32'd1);
        chk("t4_m1_rdata", 32'(m1_if.rdata), 32'd0);
        chk("t4_m0_rdy", 32'(m0_if.rdy), 32'd0);
        chk("t4_wdata", 32'(bus_if.wdata), 32'hA5);
        tick();
        bus_if.rdy = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("t4_no_regrant", 32'(gnt), 32'd0);

        // reset during BUSY
        m1_if.req = 1; m1_if.write = 0; m1_if.addr = 16'h0042;
        tick();
        tick();
        res = 1; bus_if.rdy = 1;
        tick();
        res = 0; bus_if.rdy = 0;
        m0_if.req = 1; m0_if.addr = 16'h0043;
        chk("t5_bus_req", 32'(bus_if.req), 32'd0);
        chk("t5_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t5_first_gnt", 32'(gnt), 32'd1);
        bus_if.rdy = 1;
        tick();
        bus_if.rdy = 0; m0_if.req = 0; m1_if.req = 0;
        tick();

        // SRAM stall: watchdog
        do_reset();
        m0_if.req = 1; m0_if.addr = 16'h0300;
        tick();
        for (int k = 0; k < WDOG - 1; k++) tick();
        chk("t6_wdog_early", 32'(wdog_err), 32'd0);
        tick();
        chk("t6_wdog_set", 32'(wdog_err), 32'(WDOG_ON));
        tick();
        bus_if.rdy = 1;
        tick();
        bus_if.rdy = 0; m0_if.req = 0;
        tick();
        chk("t6_wdog_sticky", 32'(wdog_err), 32'(WDOG_ON));
        do_reset();
        chk("t6_wdog_clear", 32'(wdog_err), 32'd0);

        // randomized traffic
        last_rdy0 = 0; last_rdy1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (last_rdy0) m0_if.req = 0;
            if (last_rdy1) m1_if.req = 0;
            if (!m0_if.req && $urandom_range(0, 2) == 0) begin
                m0_if.req = 1; m0_if.write = 1'($urandom_range(0, 1));
                m0_if.addr = 16'($urandom); m0_if.wdata = 8'($urandom);
            end
            if (!m1_if.req && $urandom_range(0, 3) != 0) begin
                m1_if.req = 1; m1_if.write = 1'($urandom_range(0, 1));
                m1_if.addr = 16'($urandom); m1_if.wdata = 8'($urandom);
            end
            m1_lock = ($urandom_range(0, 3) != 0);
            bus_if.rdata = 8'($urandom);
            if (mb_busy) begin
                if (sram_wait == 0) begin
                    bus_if.rdy = 1;
                    sram_wait = $urandom_range(0, 3);
                end else begin
                    bus_if.rdy = 0;
                    sram_wait--;
                end
            end else begin
                bus_if.rdy = ($urandom_range(0, 7) == 0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
